control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Moore FSM sequencing the K&S data_path. Consumes decoded_instruction and registered ALU
//  flags; drives PC/IR/register-bank/flag enables, bus muxes, ALU operation and RAM write.
//  Sits beside data_path in the CPU top. Also provides halt status and a retired-instruction counter.
// PARAMETERS
//  CNT_W  16  width of retired_count (saturating)
// PORTS
//  clk                  in   1      single clock, all state on rising edge
//  rst_n                in   1      reset, synchronous, active-low
//  decoded_instruction  in   enum   decoded_instruction_type from data_path (IR-based)
//  zero_op              in   1      registered zero flag
//  neg_op               in   1      registered negative flag
//  unsigned_overflow    in   1      registered unsigned-overflow flag
//  branch               out  1      1: PC loads mem_addr; 0: PC+1 (only when pc_enable)
//  pc_enable            out  1      PC update strobe
//  ir_enable            out  1      IR capture strobe
//  addr_sel             out  1      0: ram_addr=PC, 1: ram_addr=mem_addr
//  c_sel                out  1      0: bus_c=data_in, 1: bus_c=alu_out
//  operation            out  2      00 OR, 01 ADD, 10 SUB, 11 AND
//  write_reg_enable     out  1      register-bank write strobe
//  flags_reg_enable     out  1      flag-register capture strobe
//  ram_write_enable     out  1      RAM write strobe (data_out at ram_addr)
//  halt                 out  1      1 while in S_HALT
//  retired_count        out  CNT_W  completed instructions
// BEHAVIOUR
//  - Reset: rst_n=0 at an edge -> state=S_RESET, retired_count=0. S_RESET drives all outputs 0
//    and goes to S_FETCH unconditionally. Reset wins over any state, including mid-instruction/HALT.
//  - Outputs are pure functions of state and decoded_instruction; any output not listed below is 0.
//  - S_FETCH: addr_sel=0, ir_enable=1 -> S_DECODE. RAM read is asynchronous; IR valid in S_DECODE.
//  - S_DECODE: pc_enable=1 for all except I_HALT; branch=taken. Next state:
//      LOAD->S_LD; STORE->S_ST_RD; MOVE/ADD/SUB/AND/OR->S_EX_RD; HALT->S_HALT;
//      branches/NOP->S_FETCH.
//    taken: BRANCH=1; BZERO=zero_op; BNZERO=!zero_op; BNEG=neg_op; BNNEG=!neg_op;
//    BOV=unsigned_overflow; BNOV=!unsigned_overflow; others 0.
//  - S_LD: addr_sel=1, c_sel=0, write_reg_enable=1 -> S_FETCH.
//  - S_ST_RD: addr_sel=1 (register-bank read settles data_out) -> S_ST_WR.
//  - S_ST_WR: addr_sel=1, ram_write_enable=1 -> S_FETCH.
//  - S_EX_RD: operation per opcode (operands settle) -> S_EX_WB.
//  - S_EX_WB: operation held, c_sel=1, write_reg_enable=1, flags_reg_enable=1 -> S_FETCH.
//    Exception: MOVE uses operation=00 (a|a) and flags_reg_enable=0.
//  - S_HALT: halt=1, all enables 0. Stays until reset.
//  - Latency (cycles, FETCH inclusive): branch/NOP 2, HALT 2 to halt=1, LOAD 3,
//    STORE/MOVE/ALU 4.
//  - Flags are written in S_EX_WB; a following branch reads them in S_DECODE >=2 cycles later.
//    No hazard logic.
//  - retired_count increments at the edge leaving each instruction's final state:
//    S_DECODE for branch/NOP, S_LD, S_ST_WR, S_EX_WB; and once on entry to S_HALT.
//    Saturates at 2^CNT_W-1. Not incremented by S_RESET.
//  - Unknown/undefined enum value is treated as NOP.
// STRUCTURE
//  - k_and_s_pkg gets: ctrl_state_t enum {S_RESET, S_FETCH, S_DECODE, S_LD, S_ST_RD,
//    S_ST_WR, S_EX_RD, S_EX_WB, S_HALT}.
//  - k_and_s_pkg also gets the ALU op constants ALU_OR/ALU_ADD/ALU_SUB/ALU_AND.
//  - k_and_s_pkg also gets function branch_taken(instr, z, n, ov).
//  - No sub-module: one state register, next-state comb block, output-decode comb block,
//    counter register.
// TESTING
//  1. rst_n=0 for 3 cycles -> all outputs 0, retired_count=0.
//     Release -> S_RESET 1 cycle, then ir_enable=1, addr_sel=0.
//  2. I_ADD -> FETCH, then DECODE (pc_enable=1, branch=0), then EX_RD (operation=01),
//     then EX_WB (01, c_sel=1, write_reg_enable=1, flags_reg_enable=1). retired_count 0->1.
//  3. I_BZERO with zero_op=1 -> DECODE branch=1, pc_enable=1. With zero_op=0 -> branch=0.
//     Both return to FETCH after 2 cycles. Repeat for BNOV with unsigned_overflow=1 -> branch=0.
//  4. I_STORE -> addr_sel=1 for 2 cycles, ram_write_enable=1 exactly 1 cycle,
//     write_reg_enable never 1.
//     I_MOVE -> operation=00, write_reg_enable=1, flags_reg_enable=0.
//  5. I_HALT -> DECODE pc_enable=0; halt=1 from next cycle with all strobes 0;
//     count +1 once then frozen. rst_n=0 -> halt=0 at next edge.
//  6. rst_n=0 during S_EX_RD -> no write_reg_enable pulse, S_RESET next.
//     CNT_W=2, 5 NOPs -> retired_count saturates at 3.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared K&S CPU types: decoded instruction set, control-unit states, ALU op codes
// and the branch-condition evaluator used during decode.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_LD, S_ST_RD,
    S_ST_WR, S_EX_RD, S_EX_WB, S_HALT
  } ctrl_state_t;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic z, input logic n, input logic ov);
    case (instr)
      I_BRANCH: return 1'b1;
      I_BZERO:  return z;
      I_BNZERO: return !z;
      I_BNEG:   return n;
      I_BNNEG:  return !n;
      I_BOV:    return ov;
      I_BNOV:   return !ov;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore sequencer for the K&S data_path: fetch/decode/execute strobes, halt status
// and a saturating retired-instruction counter.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        retired_count
);

  ctrl_state_t state, next_state;
  logic        retire;

  // MOVE rides through the ALU as a|a, so it shares the OR encoding.
  function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
    case (instr)
      I_ADD:   return ALU_ADD;
      I_SUB:   return ALU_SUB;
      I_AND:   return ALU_AND;
      default: return ALU_OR;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                             next_state = S_LD;
          I_STORE:                            next_state = S_ST_RD;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR:  next_state = S_EX_RD;
          I_HALT:                             next_state = S_HALT;
          default:                            next_state = S_FETCH;
        endcase
      end
      S_LD:     next_state = S_FETCH;
      S_ST_RD:  next_state = S_ST_WR;
      S_ST_WR:  next_state = S_FETCH;
      S_EX_RD:  next_state = S_EX_WB;
      S_EX_WB:  next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_RESET;
    endcase
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_OR;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      S_FETCH:  ir_enable = 1'b1;
      S_DECODE: begin
        pc_enable = (decoded_instruction != I_HALT);
        branch    = branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow);
      end
      S_LD: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_ST_RD:  addr_sel = 1'b1;
      S_ST_WR: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_EX_RD:  operation = alu_op(decoded_instruction);
      S_EX_WB: begin
        operation        = alu_op(decoded_instruction);
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = (decoded_instruction != I_MOVE);
      end
      S_HALT:   halt = 1'b1;
      default:  ;
    endcase
  end

  // A DECODE that leads to FETCH or HALT is the last cycle of a branch/NOP/HALT.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_DECODE:               retire = (next_state == S_FETCH) || (next_state == S_HALT);
      S_LD, S_ST_WR, S_EX_WB: retire = 1'b1;
      default:                retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      retired_count <= '0;
    else if (retire && (retired_count != {CNT_W{1'b1}}))
      retired_count <= retired_count + 1'b1;
  end

endmodule
